// File: rtl/nor_latch_pkg.sv
// Shared types and defaults for the clocked NOR-style set/reset latch.
package nor_latch_pkg;

  typedef enum logic [1:0] {
    HOLD_Q0   = 2'b00,
    HOLD_Q1   = 2'b01,
    FORBIDDEN = 2'b10
  } mode_t;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam logic        RST_Q_DEF       = 1'b0;

  function automatic mode_t reset_mode(input logic rst_q);
    return rst_q ? HOLD_Q1 : HOLD_Q0;
  endfunction

endpackage

// File: rtl/nor_latch_sync.sv
// N-stage single-bit synchronizer with asynchronous active-low clear.
module nor_latch_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        ff[i] <= ff[i-1];
      end
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/nor_latch.sv
// Clocked model of a NOR set/reset latch: synchronized set/reset drive a 2-bit mode register.
// Pulses on set/reset shorter than one clk period are not guaranteed to be captured.
module nor_latch
  import nor_latch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter logic        RST_Q       = RST_Q_DEF
) (
  output logic q,
  output logic qb,
  input  logic set,
  input  logic reset,
  input  logic clk,
  input  logic rst_n,
  output logic invalid
);

  localparam mode_t RST_MODE = reset_mode(RST_Q);

  logic  s;
  logic  r;
  mode_t mode;
  mode_t mode_next;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign s = set;
    assign r = reset;
  end else begin : g_sync
    nor_latch_sync #(.STAGES(SYNC_STAGES)) u_sync_set (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (set),
      .q     (s)
    );
    nor_latch_sync #(.STAGES(SYNC_STAGES)) u_sync_reset (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (reset),
      .q     (r)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mode <= RST_MODE;
    else        mode <= mode_next;
  end

  // Hold only keeps HOLD_Q1; leaving FORBIDDEN (or an unused code) resolves to q=0.
  always_comb begin
    mode_next = mode;
    unique case ({s, r})
      2'b11:   mode_next = FORBIDDEN;
      2'b10:   mode_next = HOLD_Q1;
      2'b01:   mode_next = HOLD_Q0;
      default: mode_next = (mode == HOLD_Q1) ? HOLD_Q1 : HOLD_Q0;
    endcase
  end

  assign q       = (mode == HOLD_Q1);
  assign qb      = (mode == HOLD_Q0);
  assign invalid = (mode == FORBIDDEN);

endmodule

// File: tb/tb_nor_latch.sv
// Self-checking bench for nor_latch (SYNC_STAGES=2): vector table, corner sequences, random run.
module tb_nor_latch;

  localparam int unsigned SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set = 1'b0;
  logic reset = 1'b0;
  logic q, qb, invalid;

  int checks = 0;
  int errors = 0;

  nor_latch #(.SYNC_STAGES(SYNC), .RST_Q(1'b0)) dut (
    .q       (q),
    .qb      (qb),
    .set     (set),
    .reset   (reset),
    .clk     (clk),
    .rst_n   (rst_n),
    .invalid (invalid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic s;
    logic r;
  } pair_t;

  typedef struct packed {
    logic s;
    logic r;
    logic eq;
    logic eqb;
    logic einv;
  } vec_t;

  // Reference: inputs wait in a queue SYNC edges deep, then the truth table is applied.
  pair_t pipe[$];
  logic  m_q, m_qb, m_inv;

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < int'(SYNC); i++) pipe.push_back('0);
    m_q = 1'b0; m_qb = 1'b1; m_inv = 1'b0;
  endtask

  task automatic model_apply(input pair_t p);
    if (p.s && p.r) begin
      m_q = 1'b0; m_qb = 1'b0; m_inv = 1'b1;
    end else if (p.s) begin
      m_q = 1'b1; m_qb = 1'b0; m_inv = 1'b0;
    end else if (p.r) begin
      m_q = 1'b0; m_qb = 1'b1; m_inv = 1'b0;
    end else if (m_inv) begin
      m_q = 1'b0; m_qb = 1'b1; m_inv = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got q/qb/inv=%b required %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one edge, compare against the model 1 ns later.
  task automatic step(input logic s, input logic r, input bit cmp);
    pair_t p;
    set = s; reset = r;
    p.s = s; p.r = r;
    pipe.push_back(p);
    @(posedge clk);
    model_apply(pipe.pop_front());
    #1;
    if (cmp) check("model", {q, qb, invalid}, {m_q, m_qb, m_inv});
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($isunknown({q, qb, invalid}) || (!invalid && qb !== ~q)) begin
        errors++;
        $display("FAIL qb_complement: got q=%b qb=%b inv=%b required qb=~q, no X", q, qb, invalid);
      end
    end
  end

  vec_t tbl[10];
  logic [2:0] seq_exp[7];

  initial begin
    // Reset held with set=1: outputs stay at reset values.
    set = 1'b1;
    #1;
    check("reset_async", {q, qb, invalid}, 3'b010);
    repeat (3) begin
      @(posedge clk); #1;
      check("reset_hold", {q, qb, invalid}, 3'b010);
    end
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check("release_edge2", {q, qb, invalid}, 3'b010);
    step(1'b1, 1'b0, 1'b1);
    check("release_edge3", {q, qb, invalid}, 3'b100);

    // Back to a clean reset state for the table.
    rst_n = 1'b0; set = 1'b0; #1; rst_n = 1'b1; model_reset();

    tbl[0] = '{1, 0, 1, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 0};
    tbl[2] = '{0, 1, 0, 1, 0};
    tbl[3] = '{0, 0, 0, 1, 0};
    tbl[4] = '{1, 1, 0, 0, 1};
    tbl[5] = '{0, 0, 0, 1, 0};
    tbl[6] = '{1, 1, 0, 0, 1};
    tbl[7] = '{1, 0, 1, 0, 0};
    tbl[8] = '{1, 1, 0, 0, 1};
    tbl[9] = '{0, 1, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      repeat (SYNC + 1) step(tbl[i].s, tbl[i].r, 1'b0);
      check("table", {q, qb, invalid}, {tbl[i].eq, tbl[i].eqb, tbl[i].einv});
    end

    // One-cycle set pulse is captured and held.
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("pulse_set", {q, qb, invalid}, 3'b100);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    check("pulse_held", {q, qb, invalid}, 3'b100);

    // Cyclic 01,10,11 then 00, one cycle each, from q=0.
    repeat (3) step(1'b0, 1'b1, 1'b1);
    seq_exp = '{3'b010, 3'b010, 3'b010, 3'b100, 3'b001, 3'b010, 3'b010};
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: step(1'b0, 1'b1, 1'b1);
        1: step(1'b1, 1'b0, 1'b1);
        2: step(1'b1, 1'b1, 1'b1);
        default: step(1'b0, 1'b0, 1'b1);
      endcase
      check("cyclic", {q, qb, invalid}, seq_exp[i]);
    end

    // Asynchronous reset mid-cycle while q=1.
    repeat (3) step(1'b1, 1'b0, 1'b1);
    check("pre_async_q1", {q, qb, invalid}, 3'b100);
    #3 rst_n = 1'b0;
    #1 check("async_from_q1", {q, qb, invalid}, 3'b010);
    @(posedge clk); #1 rst_n = 1'b1; model_reset();

    // Asynchronous reset while forbidden.
    repeat (3) step(1'b1, 1'b1, 1'b1);
    check("pre_async_forbidden", {q, qb, invalid}, 3'b001);
    #2 rst_n = 1'b0;
    #1 check("async_from_forbidden", {q, qb, invalid}, 3'b010);
    @(posedge clk); #1 rst_n = 1'b1; model_reset();

    // Random run against the model.
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 3));
      step(v[1], v[0], 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nor_latch.md
NOR_LATCH -- requirements
Module: nor_latch

Interface
REQ-001 Parameter SYNC_STAGES, default 2, is the number of synchronizer flops on set and reset; 0 means inputs are used directly with no synchronization.
REQ-002 Parameter RST_Q, default 1'b0, is the value q takes while reset is held.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port q, output, 1 bit: latch true output.
REQ-006 Port qb, output, 1 bit: latch complement output.
REQ-007 Port set, input, 1 bit: active-high set request; may be asynchronous to clk.
REQ-008 Port reset, input, 1 bit: active-high clear request; this is a data input and is distinct from rst_n.
REQ-009 Port invalid, output, 1 bit: high while the forbidden combination set=1, reset=1 is in effect.
REQ-010 Ports shall be declared in the order q, qb, set, reset, clk, rst_n, invalid, so that positional instantiation (q, qb, set, reset) binds correctly.

Function
REQ-011 Each rising clk edge samples the synchronized pair (s, r); q, qb and invalid are registered outputs.
REQ-012 Latency from a set/reset change to an output change shall be SYNC_STAGES+1 clk edges (1 edge when SYNC_STAGES=0).
REQ-013 Truth table for s,r = 0,0: hold; q and qb keep their previous values.
REQ-014 Truth table for s,r = 1,0: q=1, qb=0.
REQ-015 Truth table for s,r = 0,1: q=0, qb=1.
REQ-016 Truth table for s,r = 1,1 (NOR forbidden state): q=0, qb=0, invalid=1.
REQ-017 When s,r goes from 1,1 to 0,0 on consecutive samples, the latch shall resolve deterministically to q=0, qb=1 (reset dominates); it shall not oscillate or go to X.
REQ-018 A transition from 1,1 to 1,0 or 0,1 shall follow REQ-014 or REQ-015 respectively on the next edge.
REQ-019 invalid shall be 0 for every input combination except 1,1.
REQ-020 Outside the forbidden state, qb shall always equal ~q.
REQ-021 Internal state shall be a 2-bit encoded mode (HOLD_Q0, HOLD_Q1, FORBIDDEN); q, qb and invalid shall be decoded from the mode register with no combinational path from inputs to outputs.
REQ-022 Input pulses shorter than one clk period are not guaranteed to be captured; this limitation shall be documented in the module header.

Reset
REQ-023 While rst_n=0: q=RST_Q, qb=~RST_Q, invalid=0, and all synchronizer flops are cleared to 0; this is asynchronous to clk.
REQ-024 Reset deassertion shall be synchronous, and the first functional sample is taken on the first rising edge after rst_n goes high.
REQ-025 Reset asserted mid-operation, including in the forbidden state, shall override all inputs immediately.

Structure
REQ-026 Package nor_latch_pkg shall hold the mode typedef (HOLD_Q0, HOLD_Q1, FORBIDDEN) and the default constants for SYNC_STAGES and RST_Q.
REQ-027 One sub-module, nor_latch_sync, shall be a parameterized N-stage, 1-bit synchronizer with asynchronous active-low clear; it is instantiated once for set and once for reset, or bypassed when SYNC_STAGES=0.

Verification (clk period 10 ns, SYNC_STAGES=2)
REQ-028 Hold rst_n=0 with set=1 -> q=0, qb=1, invalid=0 throughout; after release, q=1 three edges later.
REQ-029 Apply set=1, reset=0 for 10 ns, then 0,0 -> q=1, qb=0 after 3 edges, and q=1 is still held 50 ns later.
REQ-030 Apply the cyclic sequence 01, 10, 11, 10 ns each, after the 00 initialisation -> q/qb follow 0/1, 1/0, 0/0 delayed 3 edges; invalid=1 only during the 11 window.
REQ-031 Drive 1,1, then 0,0 -> q=0, qb=1, invalid=0; no X on any output.
REQ-032 Assert rst_n low asynchronously while q=1 and between clk edges -> q=0 immediately, before the next edge.
REQ-033 Run 1000 cycles of random set/reset with an assertion that qb==~q whenever invalid=0, and that the outputs match a delayed reference model.
